// File: rtl/audio_nios_nios_cpu_debug_oci_sched.sv
// Scheduler sharing the single-port OCI debug memory between latched JTAG actions and CPU monitor accesses.
// Optional build macro: DBG_OCI_SCHED_DEBUGACK_LOCK_EN (debugack input locks out CPU grants).
module audio_nios_nios_cpu_debug_oci_sched #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
`ifdef DBG_OCI_SCHED_DEBUGACK_LOCK_EN
    input  logic              debugack,
`endif
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_r, state_next_s;

    logic              pend_wr_r, pend_rd_r, pend_rd_inc_r;
    logic [31:0]       wbuf_r;
    logic [ADDR_W-1:0] jtag_addr_r;
    logic              last_grant_r;   // 1: CPU was served last
    logic              op_jtag_r, op_we_r, op_inc_r;
    logic [ADDR_W-1:0] op_addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       rdata_r;

    logic              cpu_ack_r, mem_we_r, mem_re_r, monitor_ready_r, monitor_error_r, busy_r;
    logic [31:0]       cpu_rdata_r, mem_wdata_r, mond_r;
    logic [ADDR_W-1:0] mem_addr_r;

    logic              cpu_ok_s, jtag_req_s, grant_jtag_s, start_req_s, done_jtag_s;
    logic              rd_take_s, wr_set_s, rd_set_s, wr_ovr_s, rd_ovr_s;
    logic              sel_we_s, sel_inc_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              unused_jdo_s;

`ifdef DBG_OCI_SCHED_DEBUGACK_LOCK_EN
    assign cpu_ok_s = cpu_req & ~debugack;
`else
    assign cpu_ok_s = cpu_req;
`endif

    assign jtag_req_s   = pend_wr_r | pend_rd_r;
    assign grant_jtag_s = jtag_req_s & (~cpu_ok_s | last_grant_r);
    assign start_req_s  = jtag_req_s | cpu_ok_s;
    assign done_jtag_s  = (state_r == ST_DONE) & op_jtag_r;
    assign rd_take_s    = (take_action_ocimem_a & jdo[34]) | take_no_action_ocimem_a;
    assign wr_set_s     = take_action_ocimem_b & ~pend_wr_r;
    assign wr_ovr_s     = take_action_ocimem_b & pend_wr_r;
    assign rd_set_s     = rd_take_s & ~pend_rd_r;
    assign rd_ovr_s     = rd_take_s & pend_rd_r;
    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    assign cpu_ack       = cpu_ack_r;
    assign cpu_rdata     = cpu_rdata_r;
    assign mem_addr      = mem_addr_r;
    assign mem_we        = mem_we_r;
    assign mem_re        = mem_re_r;
    assign mem_wdata     = mem_wdata_r;
    assign MonDReg       = mond_r;
    assign monitor_ready = monitor_ready_r;
    assign monitor_error = monitor_error_r;
    assign busy          = busy_r;

    // Operation fields of whichever side wins the grant; JTAG writes outrank JTAG reads
    always_comb begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
        sel_inc_s   = 1'b0;
        if (grant_jtag_s) begin
            sel_we_s    = pend_wr_r;
            sel_addr_s  = jtag_addr_r;
            sel_wdata_s = wbuf_r;
            sel_inc_s   = pend_wr_r | pend_rd_inc_r;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
            sel_inc_s   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s) state_next_s = ST_ISSUE;
                else             state_next_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (op_we_r) state_next_s = ST_DONE;
                else         state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) state_next_s = ST_DONE;
                else                        state_next_s = ST_WAIT;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // JTAG side: pending latches, address pointer and the JTAG-visible status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_wr_r       <= 1'b0;
            pend_rd_r       <= 1'b0;
            pend_rd_inc_r   <= 1'b0;
            wbuf_r          <= 32'd0;
            jtag_addr_r     <= {ADDR_W{1'b0}};
            monitor_error_r <= 1'b0;
            monitor_ready_r <= 1'b0;
            mond_r          <= 32'd0;
        end else begin
            if (wr_set_s) wbuf_r <= jdo[34:3];
            pend_wr_r <= wr_set_s | (pend_wr_r & ~(done_jtag_s & op_we_r));
            pend_rd_r <= rd_set_s | (pend_rd_r & ~(done_jtag_s & ~op_we_r));
            if (rd_set_s) pend_rd_inc_r <= take_no_action_ocimem_a;

            // A fresh address load outranks the post-op increment
            if (take_action_ocimem_a)         jtag_addr_r <= jdo[ADDR_W+16:17];
            else if (done_jtag_s && op_inc_r) jtag_addr_r <= jtag_addr_r + ADDR_W'(1'b1);

            if (wr_ovr_s || rd_ovr_s)                 monitor_error_r <= 1'b1;
            else if (take_action_ocimem_a && jdo[35]) monitor_error_r <= 1'b0;

            if (done_jtag_s)                                   monitor_ready_r <= 1'b1;
            else if (state_r == ST_IDLE && grant_jtag_s)       monitor_ready_r <= 1'b0;

            if (done_jtag_s && !op_we_r) mond_r <= rdata_r;
        end
    end

    // Operation sequencing: grant latch, memory strobes, read capture and CPU completion
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
            op_jtag_r    <= 1'b0;
            op_we_r      <= 1'b0;
            op_inc_r     <= 1'b0;
            op_addr_r    <= {ADDR_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            rdata_r      <= 32'd0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 32'd0;
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
            cpu_ack_r    <= 1'b0;
            cpu_rdata_r  <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            mem_we_r  <= 1'b0;
            mem_re_r  <= 1'b0;
            cpu_ack_r <= 1'b0;
            busy_r    <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start_req_s) begin
                        op_jtag_r   <= grant_jtag_s;
                        op_we_r     <= sel_we_s;
                        op_inc_r    <= sel_inc_s;
                        op_addr_r   <= sel_addr_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        mem_we_r    <= sel_we_s;
                        mem_re_r    <= ~sel_we_s;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= CNT_W'(RD_LAT - 1);
                    if (op_we_r && !op_jtag_r) cpu_ack_r <= 1'b1;
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1'b1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rdata_r <= mem_rdata;
                        if (!op_jtag_r) begin
                            cpu_ack_r   <= 1'b1;
                            cpu_rdata_r <= mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    last_grant_r <= ~op_jtag_r;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_nios_nios_cpu_debug_oci_sched.sv
// Scoreboard bench for the OCI debug memory scheduler: expected memory operations, CPU
// completions and MonDReg values are queued by a reference model and checked by a monitor.
module tb_audio_nios_nios_cpu_debug_oci_sched;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset_n;
    logic [37:0] jdo;
    logic take_a, take_b, take_no;
    logic cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic cpu_ack;
    logic [31:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_we, mem_re;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] MonDReg;
    logic monitor_ready, monitor_error, busy;
`ifdef DBG_OCI_SCHED_DEBUGACK_LOCK_EN
    logic debugack;
`endif

    audio_nios_nios_cpu_debug_oci_sched #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
`ifdef DBG_OCI_SCHED_DEBUGACK_LOCK_EN
        .debugack(debugack),
`endif
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
        .take_no_action_ocimem_a(take_no),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
        .monitor_error(monitor_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment memory: data appears exactly RD_LAT cycles after the read strobe, junk otherwise
    logic [31:0] ram [DEPTH];
    logic [31:0] pipe_d [RD_LAT];
    logic        pipe_v [RD_LAT];
    logic [31:0] junk;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        pipe_d[0] <= ram[mem_addr];
        pipe_v[0] <= mem_re;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
        junk <= $urandom;
    end
    assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

    typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [31:0] data; } op_t;
    op_t         exp_mem[$];
    op_t         exp_cpu[$];
    logic [31:0] exp_mon[$];

    // Reference model state
    logic [31:0]       model_mem [DEPTH];
    logic [ADDR_W-1:0] jaddr;
    logic [31:0]       mond;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe, ack and rising monitor_ready must match the next queued expectation
    logic prev_ready = 1'b0;
    op_t  mon_e;
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            check("strobe_exclusive", 32'(mem_we & mem_re), 32'd0);
            if (exp_mem.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = exp_mem.pop_front();
                check("mem_we", 32'(mem_we), 32'(mon_e.we));
                check("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
                if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.data);
            end
        end
        if (cpu_ack) begin
            if (exp_cpu.size() == 0) check("cpu_ack_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = exp_cpu.pop_front();
                if (!mon_e.we) check("cpu_rdata", cpu_rdata, mon_e.data);
            end
        end
        if (monitor_ready && !prev_ready) begin
            if (exp_mon.size() == 0) check("ready_unexpected", 32'd1, 32'd0);
            else check("MonDReg", MonDReg, exp_mon.pop_front());
        end
        prev_ready <= monitor_ready;
    end

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return ADDR_W'((int'(a) + 1) % DEPTH);
    endfunction

    task automatic exp_jwrite(input logic [31:0] d);
        exp_mem.push_back('{1'b1, jaddr, d});
        model_mem[jaddr] = d;
        exp_mon.push_back(mond);
        jaddr = next_addr(jaddr);
    endtask

    task automatic exp_jread(input bit inc);
        exp_mem.push_back('{1'b0, jaddr, 32'd0});
        mond = model_mem[jaddr];
        exp_mon.push_back(mond);
        if (inc) jaddr = next_addr(jaddr);
    endtask

    task automatic exp_cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_mem.push_back('{we, a, d});
        exp_cpu.push_back('{we, a, we ? d : model_mem[a]});
        if (we) model_mem[a] = d;
    endtask

    function automatic logic [37:0] jdo_a(input logic [ADDR_W-1:0] a, input logic rd, input logic clr);
        logic [37:0] d;
        d = 38'd0;
        d[ADDR_W+16:17] = a;
        d[34] = rd;
        d[35] = clr;
        return d;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] d;
        d = 38'd0;
        d[34:3]  = data;
        d[2:0]   = 3'($urandom);
        d[37:36] = 2'($urandom);
        return d;
    endfunction

    // kind 0: take_action_ocimem_a, 1: take_action_ocimem_b, 2: take_no_action_ocimem_a
    task automatic pulse(input int kind, input logic [37:0] d);
        @(negedge clk);
        jdo = d;
        take_a  = (kind == 0);
        take_b  = (kind == 1);
        take_no = (kind == 2);
        @(negedge clk);
        take_a = 1'b0; take_b = 1'b0; take_no = 1'b0;
    endtask

    task automatic load_addr(input logic [ADDR_W-1:0] a, input logic rd, input logic clr);
        jaddr = a;
        if (rd) exp_jread(1'b0);
        pulse(0, jdo_a(a, rd, clr));
    endtask

    // Called at a negedge; holds the request until the ack is seen
    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (!got) check("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_mem.size() != 0 || exp_cpu.size() != 0 || exp_mon.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k, acks;
        logic [31:0] d1, d2;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = 32'd0;
            model_mem[i] = 32'd0;
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 32'd0;
        end
        reset_n = 1'b0; jdo = 38'd0; take_a = 1'b0; take_b = 1'b0; take_no = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 32'd0;
`ifdef DBG_OCI_SCHED_DEBUGACK_LOCK_EN
        debugack = 1'b0;
`endif
        jaddr = '0; mond = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_flags", 32'({cpu_ack, mem_we, mem_re, monitor_ready, monitor_error, busy}), 32'd0);
        check("rst_MonDReg", MonDReg, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_bus", 32'(mem_addr) | mem_wdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Write then read back at 0x10, with latency checks on the read
        load_addr(8'h10, 1'b0, 1'b0);
        exp_jwrite(32'hDEADBEEF);
        pulse(1, jdo_b(32'hDEADBEEF));
        wait_drain();
        load_addr(8'h10, 1'b1, 1'b0);
        k = 0;
        while (!mem_re && k < 20) begin @(negedge clk); k++; end
        check("rd_issue_latency", 32'(k), 32'd1);
        k = 0;
        while (!monitor_ready && k < 20) begin @(negedge clk); k++; end
        check("rd_done_latency", 32'(k), 32'(RD_LAT + 2));
        check("MonDReg_write_read", MonDReg, 32'hDEADBEEF);
        wait_drain();

        // Auto-increment wrap 0xFF -> 0x00
        exp_cpu_op(1'b1, 8'hFF, 32'hA5A5_0FF0); cpu_op(1'b1, 8'hFF, 32'hA5A5_0FF0, w);
        exp_cpu_op(1'b1, 8'h00, 32'h5A5A_1234); cpu_op(1'b1, 8'h00, 32'h5A5A_1234, w);
        wait_drain();
        load_addr(8'hFF, 1'b0, 1'b0);
        exp_jread(1'b1); pulse(2, 38'({$urandom, $urandom})); wait_drain();
        exp_jread(1'b1); pulse(2, 38'({$urandom, $urandom})); wait_drain();
        check("MonDReg_after_wrap", MonDReg, 32'h5A5A_1234);

        // Overrun: second write pulse while the first is still pending is dropped
        d1 = $urandom; d2 = $urandom;
        exp_cpu_op(1'b0, 8'h10, 32'd0);
        exp_jwrite(d1);
        fork
            cpu_op(1'b0, 8'h10, 32'd0, w);
            begin pulse(1, jdo_b(d1)); pulse(1, jdo_b(d2)); end
        join
        wait_drain();
        check("overrun_error_set", 32'(monitor_error), 32'd1);
        load_addr(8'h40, 1'b0, 1'b1);
        check("overrun_error_clear", 32'(monitor_error), 32'd0);
        load_addr(8'h01, 1'b1, 1'b0);
        wait_drain();

        // Reset while a CPU read sits in WAIT
        exp_mem.push_back('{1'b0, 8'h20, 32'd0});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        k = 0;
        while (!mem_re && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        reset_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("midrst_flags", 32'({cpu_ack, mem_we, mem_re, monitor_ready, monitor_error, busy}), 32'd0);
        check("midrst_MonDReg", MonDReg, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        jaddr = '0; mond = 32'd0;
        @(negedge clk);

        // Contention right after reset: JTAG first, then CPU
        d1 = $urandom;
        exp_jwrite(d1);
        exp_cpu_op(1'b0, 8'h20, 32'd0);
        pulse(1, jdo_b(d1));
        cpu_op(1'b0, 8'h20, 32'd0, w);
        wait_drain();
        // After a JTAG-only op, contention goes to the CPU first
        exp_jread(1'b1); pulse(2, 38'd0); wait_drain();
        d2 = $urandom;
        exp_cpu_op(1'b0, 8'h00, 32'd0);
        exp_jwrite(d2);
        pulse(1, jdo_b(d2));
        cpu_op(1'b0, 8'h00, 32'd0, w);
        wait_drain();

`ifdef DBG_OCI_SCHED_DEBUGACK_LOCK_EN
        // debugack locks out the CPU while JTAG proceeds
        debugack = 1'b1;
        exp_jread(1'b1);
        exp_cpu_op(1'b0, 8'h10, 32'd0);
        fork
            cpu_op(1'b0, 8'h10, 32'd0, w);
            begin
                pulse(2, 38'd0);
                acks = 0;
                repeat (20) begin @(negedge clk); if (cpu_ack) acks++; end
                check("lock_no_ack", 32'(acks), 32'd0);
                debugack = 1'b0;
                k = 0;
                while (!cpu_ack && k < 20) begin @(negedge clk); k++; end
                check("unlock_ack_latency", 32'(k <= RD_LAT + 3), 32'd1);
            end
        join
        wait_drain();
`endif

        // Randomized mix, one operation at a time
        for (int it = 0; it < 40; it++) begin
            logic [ADDR_W-1:0] ra;
            logic [31:0] rd;
            ra = ADDR_W'($urandom);
            rd = $urandom;
            case ($urandom_range(0, 4))
                0: begin exp_cpu_op(1'b1, ra, rd); cpu_op(1'b1, ra, rd, w); end
                1: begin exp_cpu_op(1'b0, ra, 32'd0); cpu_op(1'b0, ra, 32'd0, w); end
                2: begin exp_jwrite(rd); pulse(1, jdo_b(rd)); end
                3: load_addr(ra, 1'b1, 1'b0);
                default: begin exp_jread(1'b1); pulse(2, 38'({$urandom, $urandom})); end
            endcase
            wait_drain();
        end
        check("error_stays_clear", 32'(monitor_error), 32'd0);
        check("queues_empty", 32'(exp_mem.size() + exp_cpu.size() + exp_mon.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
